// File: rtl/bus_pkg.sv
// Shared types and constants for the bus responder: FSM states, command
// encoding and the filler byte returned for out-of-range reads.
package bus_pkg;

    localparam int         ADDR_W_DEF = 20;
    localparam logic       CMD_READ   = 1'b0;
    localparam logic       CMD_WRITE  = 1'b1;
    localparam logic [7:0] OOR_DATA   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_DONE
    } state_e;

endpackage

// File: rtl/bus_responder_if.sv
// Requester <-> responder signal bundle; master drives the request side,
// slave is the memory/I-O responder.
interface bus_responder_if
    import bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              Req;
    logic              RD_WR;
    logic [ADDR_W-1:0] Direction;
    logic [1:0]        Len;
    logic [7:0]        Data_In;
    logic [7:0]        Data_Out;
    logic              Data_OE;
    logic              Ready;
    logic              Busy;
    logic              Done;
    logic              Err;

    modport master (
        output Req, RD_WR, Direction, Len, Data_In,
        input  Data_Out, Data_OE, Ready, Busy, Done, Err
    );

    modport slave (
        input  Req, RD_WR, Direction, Len, Data_In,
        output Data_Out, Data_OE, Ready, Busy, Done, Err
    );

endinterface

// File: rtl/byte_mem.sv
// Single-port byte array: synchronous write, asynchronous read, no reset.
module byte_mem #(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/bus_responder.sv
// Memory-side bus responder: after WAIT_STATES idle cycles it moves 1-4 bytes,
// one per cycle, at sequential addresses; out-of-range beats flag Err.
module bus_responder
    import bus_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic          clk,
    input  logic          rst,
    bus_responder_if.slave bus
);

    localparam logic [2:0] WAIT_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [1:0]        len_q;
    logic [1:0]        beat_q;
    logic [2:0]        wait_q;
    logic              cmd_q;
    logic              ready_q;
    logic              oe_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [7:0]        rdata;
    logic              mem_we;

    function automatic logic oor(input logic [ADDR_W-1:0] a);
        return (a >> MEM_AW) != '0;
    endfunction

    assign addr_d = addr_q + ADDR_W'(1);
    assign mem_we = ready_q && (cmd_q == CMD_WRITE) && !oor(addr_q);

    byte_mem #(.AW(MEM_AW)) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (addr_q[MEM_AW-1:0]),
        .wdata_i (bus.Data_In),
        .rdata_o (rdata)
    );

    // Err is updated on the edge that starts a beat, so it is already high
    // during the first out-of-range beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            cmd_q   <= CMD_READ;
            ready_q <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.Req) begin
                        addr_q <= bus.Direction;
                        cmd_q  <= bus.RD_WR;
                        len_q  <= bus.Len;
                        beat_q <= '0;
                        wait_q <= '0;
                        busy_q <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_q <= ST_WAIT;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= ST_XFER;
                            ready_q <= 1'b1;
                            oe_q    <= (bus.RD_WR == CMD_READ);
                            err_q   <= oor(bus.Direction);
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= ST_XFER;
                        ready_q <= 1'b1;
                        oe_q    <= (cmd_q == CMD_READ);
                        err_q   <= oor(addr_q);
                    end else begin
                        wait_q <= wait_q + 3'd1;
                    end
                end
                ST_XFER: begin
                    addr_q <= addr_d;
                    if (beat_q == len_q) begin
                        state_q <= ST_DONE;
                        ready_q <= 1'b0;
                        oe_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        beat_q <= beat_q + 2'd1;
                        err_q  <= err_q | oor(addr_d);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.Data_Out = !oe_q ? '0 : (oor(addr_q) ? OOR_DATA : rdata);
    assign bus.Data_OE  = oe_q;
    assign bus.Ready    = ready_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Err      = err_q;

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Memory-side responder for the bus interface unit. It accepts a 20-bit physical address (the address-unit Direction output) together with a read/write command and a byte count.
- After a programmable number of wait states it transfers 1–4 bytes over an 8-bit data path, one byte per cycle, at sequential addresses.
- It models the external memory and I/O end of the bus, and serves as a bench target for the instruction queue and the in/out buffer.

Parameters:
- ADDR_W, 20, physical address width.
- MEM_AW, 10, internal byte-array address width (array size is 2^MEM_AW bytes).
- WAIT_STATES, 2, idle cycles between request acceptance and the first data beat (legal range 0–7).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Req  in  1  request strobe, sampled only in IDLE.
- RD_WR  in  1  command: 1 = write, 0 = read. Sampled with Req.
- Direction  in  20  start byte address. Sampled with Req.
- Len  in  2  beat count minus 1 (0 → 1 byte, 3 → 4 bytes). Sampled with Req.
- Data_In  in  8  write data, sampled on each write beat.
- Data_Out  out  8  read data, valid while Ready=1 on a read.
- Data_OE  out  1  drive enable for the external tri-state. High only on read beats.
- Ready  out  1  high for one cycle per transferred byte.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse after the last beat.
- Err  out  1  sticky-per-transaction flag: some beat addressed beyond the array.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - Data_Out=8'h00; Data_OE, Ready, Busy, Done and Err all 0.
  - Internal address, beat and wait counters cleared.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, XFER, DONE.
- IDLE:
  - Req=1 latches Direction, RD_WR and Len, and clears Err.
  - Next state is WAIT if WAIT_STATES>0, else XFER.
- WAIT:
  - Counts WAIT_STATES cycles, then moves to XFER.
  - Ready=0, Busy=1.
- XFER:
  - One beat per cycle, Ready=1 every cycle, no stalls between beats.
  - Read beat: Data_Out = mem[addr], Data_OE=1.
  - Write beat: mem[addr] <= Data_In at the clock edge ending the beat; Data_OE=0.
  - After each beat, addr increments modulo 2^ADDR_W (20'hFFFFF wraps to 20'h00000).
  - After Len+1 beats, next state is DONE.
- DONE:
  - Done=1 and Busy=1 for exactly one cycle, then IDLE.
  - A new Req is accepted in the cycle after DONE, not during it.
- Latency: Req sampled at edge N → first Ready at cycle N+1+WAIT_STATES → Done at cycle N+2+WAIT_STATES+Len.
- Out-of-range beats (addr ≥ 2^MEM_AW):
  - Read returns 8'hFF; write is discarded.
  - Err is set and held until the next accepted Req.
  - Ready is still asserted, so the bus never hangs.
- Req while Busy=1 is ignored. No queuing: the requester must wait for Done.
- Inputs Direction, RD_WR and Len may change after acceptance; only the latched copies are used.
- Reset mid-transaction: immediate return to IDLE. Writes already committed stay in memory; no Done pulse.

Decomposition:
- Shared package (bus_pkg): the FSM state enum, the RD/WR encoding constants (CMD_READ=0, CMD_WRITE=1), ADDR_W default, and OOR_DATA=8'hFF.
- One sub-module is natural: byte_mem, a single-port synchronous-write, asynchronous-read array (2^MEM_AW x 8, no reset).
- The FSM, counters and address datapath stay in bus_responder.

Test Plan:
1. Preload byte_mem with 0x12, 0x34, 0x56, 0x78 at addresses 0x00010–0x00013; read Len=3 at 0x00010 with WAIT_STATES=2 → Ready on cycles N+3..N+6 with Data_Out 12, 34, 56, 78; Done at N+7; Err=0.
2. Write Len=1 at 0x00020 with Data_In AA then BB; then read Len=1 at 0x00020 → AA, BB; Data_OE=0 during the write beats and 1 during the read beats.
3. Read Len=2 at 0x003FF (MEM_AW=10) → first byte from memory, the next two 0xFF; Err=1 after beat 2 and still 1 in IDLE; cleared on the next Req.
4. Read at 0xFFFFF with Len=1 → second beat address wraps to 0x00000 and returns mem[0]; Err=1 from the first beat.
5. Assert Req again during WAIT and during XFER → ignored; exactly Len+1 Ready pulses and one Done; a Req in the DONE cycle is ignored and the next-cycle Req is accepted.
6. Drive rst=0 between beats 2 and 3 of a Len=3 write → all outputs 0 asynchronously, no Done; beats 1–2 present in memory, beats 3–4 unchanged. Repeat with WAIT_STATES=0 → first Ready at N+1.
